// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..8 data bits, optional parity, 1/2 stop bits, 3-sample voting.
// Define UART_RX_BREAK_DET_EN to report an all-zero frame as a break instead of a framing error.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 7292,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_DV,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy,
    output logic                 o_Break
);

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   HALF      = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]   LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_IDX  = 3'(DATA_BITS - 1);
    localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state, state_next;
    logic          rx_meta, rx_sync;
    logic [2:0]    hist;
    logic          vote;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    data_reg;
    logic          par_pend, frm_pend;
    logic          bit_tick, stop_done, par_expect, is_break;

    assign vote       = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign bit_tick   = (cnt == LAST);
    assign par_expect = (PARITY == 2) ? (^data_reg[DATA_BITS-1:0]) : (~^data_reg[DATA_BITS-1:0]);
    assign o_Busy     = (state != S_IDLE);

    // Synchroniser and vote history idle high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            hist    <= 3'b111;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
            hist    <= {hist[1:0], rx_sync};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        stop_done  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (!rx_sync) state_next = S_START;
            end
            S_START: begin
                if (cnt == HALF) begin
                    cnt_next   = '0;
                    state_next = vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_next = '0;
                    if (bit_idx == LAST_IDX) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    cnt_next   = '0;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    cnt_next = '0;
                    if (stop_idx == LAST_STOP) begin
                        stop_done  = 1'b1;
                        // A line still low after a bad frame must not re-trigger a start
                        state_next = (is_break || frm_pend || !vote) ? S_WAIT_HIGH : S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_sync) state_next = S_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            data_reg     <= '0;
            par_pend     <= 1'b0;
            frm_pend     <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Rx_DV      <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
        end else begin
            o_Rx_DV <= stop_done && !is_break;
            case (state)
                S_IDLE: begin
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_pend <= 1'b0;
                    frm_pend <= 1'b0;
                end
                S_DATA: begin
                    if (bit_tick) begin
                        data_reg[bit_idx] <= vote;
                        bit_idx           <= bit_idx + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_tick && (vote != par_expect)) par_pend <= 1'b1;
                end
                S_STOP: begin
                    if (bit_tick) begin
                        stop_idx <= stop_idx + 1'b1;
                        if (!vote) frm_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
            // The final stop vote is folded in here since frm_pend only sees it a cycle later
            if (stop_done && !is_break) begin
                o_Rx_Byte    <= data_reg[DATA_BITS-1:0];
                o_Parity_Err <= par_pend;
                o_Frame_Err  <= frm_pend | ~vote;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit_low, first_stop_low;

    assign is_break = (data_reg[DATA_BITS-1:0] == '0) &&
                      ((PARITY == 0) || par_bit_low) &&
                      ((stop_idx == 1'b0) ? !vote : first_stop_low);

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit_low    <= 1'b0;
            first_stop_low <= 1'b0;
            o_Break        <= 1'b0;
        end else begin
            o_Break <= stop_done && is_break;
            if (state == S_PARITY && bit_tick) par_bit_low <= !vote;
            if (state == S_STOP && bit_tick && stop_idx == 1'b0) first_stop_low <= !vote;
        end
    end
`else
    assign is_break = 1'b0;
    assign o_Break  = 1'b0;
`endif

endmodule
